lfsr_word_packer: RTL

LFSR_WORD_PACKER -- requirements
Module: lfsr_word_packer

---
 rtl/lfsr_word_packer.sv | 108 ++++++++++
 1 files changed

// File: rtl/lfsr_word_packer.sv
// Packs a stream of random bytes into little-endian 32-bit words and queues
// them in a small FIFO; words completing while the FIFO is full are dropped and counted.
module lfsr_word_packer #(
   parameter int DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [7:0]                 in_bits,
   input  logic                       flush,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [31:0]                out_word,
   output logic                       overflow,
   output logic [7:0]                 drop_cnt,
   output logic [$clog2(DEPTH):0]     level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [1:0]              idx_q, idx_d;
   logic [23:0]             asm_q, asm_d;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]           level_q, level_d;
   logic                    overflow_q, overflow_d;
   logic [7:0]              drop_cnt_q, drop_cnt_d;
   logic [DEPTH-1:0][31:0]  mem_q, mem_d;

   logic        accept, complete, pop, push, full;
   logic [31:0] word;

   always_comb begin
      accept   = in_valid && !flush;
      complete = accept && (idx_q == 2'd3);
      word     = {in_bits, asm_q};
      full     = (level_q == LW'(DEPTH));
      pop      = (level_q != '0) && out_ready;
      // A full FIFO can still take the word if the head leaves on the same edge.
      push     = complete && (!full || pop);

      idx_d      = idx_q;
      asm_d      = asm_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      mem_d      = mem_q;

      if (flush) begin
         idx_d = 2'd0;
         asm_d = '0;
      end else if (complete) begin
         idx_d = 2'd0;
         asm_d = '0;
      end else if (accept) begin
         idx_d = idx_q + 2'd1;
         case (idx_q)
            2'd0:    asm_d[7:0]   = in_bits;
            2'd1:    asm_d[15:8]  = in_bits;
            default: asm_d[23:16] = in_bits;
         endcase
      end

      if (push) begin
         mem_d[wr_ptr_q] = word;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LW'(push) - LW'(pop);

      if (complete && !push) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q      <= '0;
         asm_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         idx_q      <= idx_d;
         asm_q      <= asm_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage needs no reset: the head is masked whenever level is zero.
   always_ff @(posedge clk) begin
      if (!rst) mem_q <= mem_d;
   end

   assign out_valid = (level_q != '0);
   assign out_word  = out_valid ? mem_q[rd_ptr_q] : 32'h0;
   assign overflow  = overflow_q;
   assign drop_cnt  = drop_cnt_q;
   assign level     = level_q;
endmodule
